// File: rtl/rat_io_responder.sv
// I/O-bus peripheral for the RAT CPU: LEDs, switch sync, interval timer
// with interrupt, and a TX byte FIFO drained over ready/valid.
module rat_io_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int SW_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          port_id,
    input  logic [7:0]          out_port,
    input  logic                io_strb,
    output logic [7:0]          in_port,
    output logic                interrupt,
    output logic [7:0]          leds,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [SW_WIDTH-1:0] sw_s1, sw_s2;
    logic                tmr_en, tmr_auto, irq_pending, fire;
    logic [15:0]         reload, counter;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic                overflow, full, empty, push_req, push, pop;

    logic wr_leds, wr_ctrl, wr_lo, wr_hi, wr_int, wr_stat;

    assign wr_leds  = io_strb && (port_id == 8'h20);
    assign wr_ctrl  = io_strb && (port_id == 8'h30);
    assign wr_lo    = io_strb && (port_id == 8'h31);
    assign wr_hi    = io_strb && (port_id == 8'h32);
    assign wr_int   = io_strb && (port_id == 8'h33);
    assign push_req = io_strb && (port_id == 8'h40);
    assign wr_stat  = io_strb && (port_id == 8'h41);

    assign fire      = tmr_en && (counter == 16'd0);
    assign interrupt = irq_pending;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    // A full FIFO still takes a byte when the head leaves the same cycle
    assign push     = push_req && (!full || pop);

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            leds  <= 8'h00;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            if (wr_leds) leds <= out_port;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_en      <= 1'b0;
            tmr_auto    <= 1'b0;
            reload      <= 16'h0000;
            counter     <= 16'h0000;
            irq_pending <= 1'b0;
        end else begin
            if (tmr_en) begin
                if (counter != 16'd0) counter <= counter - 16'd1;
                else if (tmr_auto)    counter <= reload;
                else                  tmr_en  <= 1'b0;
            end
            // Register writes override the count step above
            if (wr_ctrl) begin
                tmr_en   <= out_port[0];
                tmr_auto <= out_port[1];
                if (!tmr_en && out_port[0]) counter <= reload;
            end
            if (wr_lo) reload[7:0]  <= out_port;
            if (wr_hi) reload[15:8] <= out_port;
            if (fire)        irq_pending <= 1'b1;
            else if (wr_int) irq_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (push) begin
                mem[wr_ptr] <= out_port;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (push_req && !push)              overflow <= 1'b1;
            else if (wr_stat && out_port[7])    overflow <= 1'b0;
        end
    end

    always_comb begin
        in_port = 8'h00;
        case (port_id)
            8'h20:   in_port = leds;
            8'h21:   in_port = 8'(sw_s2);
            8'h30:   in_port = {6'b0, tmr_auto, tmr_en};
            8'h31:   in_port = reload[7:0];
            8'h32:   in_port = reload[15:8];
            8'h33:   in_port = {7'b0, irq_pending};
            8'h41:   in_port = {overflow, full, empty, 5'(count)};
            default: in_port = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rat_io_responder.sv
// Directed bench for rat_io_responder with a TX byte scoreboard.
module tb_rat_io_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] port_id, out_port, in_port, leds, tx_data;
    logic       io_strb, interrupt, tx_valid, tx_ready;
    logic [7:0] sw;

    int nchecks = 0;
    int nfail   = 0;
    logic [7:0] sb[$];

    rat_io_responder #(.FIFO_DEPTH(4), .SW_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .io_strb(io_strb), .in_port(in_port), .interrupt(interrupt),
        .leds(leds), .sw(sw), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] id,
                          input logic [7:0] exp);
        port_id = id;
        #1;
        check(tag, in_port, exp);
    endtask

    task automatic io_write(input logic [7:0] id, input logic [7:0] d);
        port_id  = id;
        out_port = d;
        io_strb  = 1'b1;
        @(posedge clk);
        #1;
        io_strb = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check({tag, "_sb_empty"}, 8'(sb.size()), 8'h00);
        check({tag, "_valid_low"}, {7'b0, tx_valid}, 8'h00);
    endtask

    // Handshake is sampled mid-cycle; the pop lands on the next edge
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                nchecks++;
                nfail++;
                $error("FAIL tx_extra observed=%h expected=none", tx_data);
            end else begin
                check("tx_byte", tx_data, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; port_id = 8'h00; out_port = 8'h00; io_strb = 1'b0;
        sw = 8'h00; tx_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst_leds", leds, 8'h00);
        check("rst_irq", {7'b0, interrupt}, 8'h00);
        check("rst_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_txdata", tx_data, 8'h00);
        chk_rd("rst_status", 8'h41, 8'h20);
        chk_rd("rst_ctrl", 8'h30, 8'h00);

        io_write(8'h20, 8'hA5);
        check("leds_a5", leds, 8'hA5);
        chk_rd("rd_leds", 8'h20, 8'hA5);
        chk_rd("rd_unmapped", 8'h55, 8'h00);
        chk_rd("rd_txdata_port", 8'h40, 8'h00);

        sw = 8'h3C;
        chk_rd("sw_t0", 8'h21, 8'h00);
        tick(1);
        chk_rd("sw_t1", 8'h21, 8'h00);
        tick(1);
        chk_rd("sw_t2", 8'h21, 8'h3C);

        io_write(8'h31, 8'h03);
        io_write(8'h32, 8'h00);
        io_write(8'h30, 8'h03);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check($sformatf("auto_quiet%0d", i), {7'b0, interrupt}, 8'h00);
        end
        tick(1);
        check("auto_fire1", {7'b0, interrupt}, 8'h01);
        io_write(8'h33, 8'h00);
        check("irq_cleared", {7'b0, interrupt}, 8'h00);
        tick(1);
        check("auto_quiet_b1", {7'b0, interrupt}, 8'h00);
        tick(1);
        check("auto_quiet_b2", {7'b0, interrupt}, 8'h00);
        io_write(8'h33, 8'h00);
        check("fire_beats_clear", {7'b0, interrupt}, 8'h01);
        chk_rd("rd_intctrl", 8'h33, 8'h01);
        io_write(8'h30, 8'h00);
        io_write(8'h33, 8'h00);
        check("irq_off", {7'b0, interrupt}, 8'h00);

        io_write(8'h31, 8'h05);
        io_write(8'h32, 8'h00);
        io_write(8'h30, 8'h01);
        chk_rd("rd_reload_lo", 8'h31, 8'h05);
        tick(5);
        check("oneshot_quiet", {7'b0, interrupt}, 8'h00);
        tick(1);
        check("oneshot_fire", {7'b0, interrupt}, 8'h01);
        chk_rd("oneshot_en_clr", 8'h30, 8'h00);
        io_write(8'h33, 8'h00);
        tick(8);
        check("oneshot_single", {7'b0, interrupt}, 8'h00);

        io_write(8'h40, 8'h11); sb.push_back(8'h11);
        io_write(8'h40, 8'h22); sb.push_back(8'h22);
        io_write(8'h40, 8'h33); sb.push_back(8'h33);
        io_write(8'h40, 8'h44); sb.push_back(8'h44);
        chk_rd("status_full", 8'h41, 8'h44);
        io_write(8'h40, 8'h55);
        chk_rd("status_ovf", 8'h41, 8'hC4);
        check("head_held", tx_data, 8'h11);
        tx_ready = 1'b1;
        drain("drain1");
        chk_rd("status_drained", 8'h41, 8'hA0);
        io_write(8'h41, 8'h80);
        chk_rd("status_ovf_clr", 8'h41, 8'h20);

        tx_ready = 1'b0;
        io_write(8'h40, 8'hA1); sb.push_back(8'hA1);
        io_write(8'h40, 8'hA2); sb.push_back(8'hA2);
        io_write(8'h40, 8'hA3); sb.push_back(8'hA3);
        io_write(8'h40, 8'hA4); sb.push_back(8'hA4);
        tx_ready = 1'b1;
        io_write(8'h40, 8'h66); sb.push_back(8'h66);
        chk_rd("full_pushpop", 8'h41, 8'h44);
        drain("drain2");
        chk_rd("status_no_ovf", 8'h41, 8'h20);

        tx_ready = 1'b0;
        io_write(8'h31, 8'h00);
        io_write(8'h30, 8'h01);
        tick(1);
        check("zero_reload_fire", {7'b0, interrupt}, 8'h01);
        io_write(8'h40, 8'h77);
        io_write(8'h40, 8'h88);
        check("pre_rst_valid", {7'b0, tx_valid}, 8'h01);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
        check("mid_rst_valid", {7'b0, tx_valid}, 8'h00);
        check("mid_rst_irq", {7'b0, interrupt}, 8'h00);
        check("mid_rst_leds", leds, 8'h00);
        chk_rd("mid_rst_status", 8'h41, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchecks, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rat_io_responder.md
Name: rat_io_responder

Overview:
- Port-mapped peripheral that sits on the CPU I/O bus, on the opposite end from the CPU core.
- Decodes OUT writes qualified by io_strb.
- Drives the CPU in_port combinationally from port_id, so IN reads are valid in the same execute cycle.
- Contains an LED register, a switch synchronizer, a 16-bit interval timer that drives the CPU interrupt line, and a small TX byte FIFO drained over a ready/valid handshake.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16)
SW_WIDTH, 8, switch input width (≤8, zero-extended on read)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
port_id  in  8  I/O address from CPU
out_port  in  8  write data from CPU
io_strb  in  1  write strobe, one cycle per OUT instruction
in_port  out  8  read data to CPU, combinational on port_id
interrupt  out  1  level interrupt to CPU input_interrupt
leds  out  8  LED register
sw  in  SW_WIDTH  asynchronous switch inputs
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts head this cycle

Behaviour:
Reset:
- Synchronous; the clk edge with rst=1 sets leds=0, timer ctrl=0, reload=0x0000, counter=0, irq_pending=0 (interrupt=0).
- FIFO empty (tx_valid=0, tx_data=0x00), overflow=0, synchronizer flops=0.
- rst has priority over every write or handshake in the same cycle.

Writes: take effect at the clk edge where io_strb=1, using port_id/out_port sampled at that edge. Writes to unmapped IDs are ignored.

Port map:
- 0x20 LEDS, R/W. A write loads leds; a read returns leds.
- 0x21 SW, R. Returns the 2-flop synchronized sw, zero-extended. Latency is 2 clk edges from an sw change.
- 0x30 TMR_CTRL, R/W:
  - bit0 EN, bit1 AUTO; read returns {6'b0, AUTO, EN}.
  - A write with EN 0→1 loads counter from reload.
- 0x31 / 0x32 TMR_RELOAD_LO / HI, R/W. Bytes of the 16-bit reload. They do not affect a running count until the next load.
- 0x33 INT_CTRL:
  - A write of any value clears irq_pending.
  - A read returns {7'b0, irq_pending}.
- 0x40 TX_DATA, W.
  - Pushes out_port into the FIFO.
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and overflow is set.
  - A read returns 0x00.
- 0x41 TX_STATUS, R/W:
  - Read returns {overflow, full, empty, count[4:0]}; count saturates at 5 bits.
  - Writing bit7=1 clears overflow.
- All other IDs read 0x00. Reads have no side effects; there is no read strobe.

Timer:
- While EN=1, each clk: if counter≠0, counter decrements by 1.
- If counter==0, the timer fires:
  - irq_pending is set.
  - If AUTO=1, counter reloads from reload.
  - Else EN clears and counter stays at 0.
- Period is reload+1 cycles; reload=0 fires every cycle while AUTO=1.
- EN=0 freezes the counter.
- Fire and an INT_CTRL write in the same cycle: the fire wins and irq_pending stays 1.
- interrupt = irq_pending, registered with no combinational path.

FIFO:
- Circular buffer with wrapping read/write pointers plus a count.
- tx_data = mem[rd_ptr]; it is held stable while tx_valid=1 and tx_ready=0.
- A pop occurs when tx_valid & tx_ready; there is no pop when empty.
- Push and pop in the same cycle: both occur and count is unchanged.
- This applies when full too: the push is accepted and overflow is not set.
- A push into an empty FIFO makes tx_valid=1 on the next cycle; there is no fall-through.
- Pointer wrap at FIFO_DEPTH-1 → 0.

Test Plan:
- Reset, then OUT 0x20←0xA5 → leds=0xA5 the next cycle. With port_id=0x20, in_port=0xA5 combinationally; with port_id=0x55, in_port=0x00.
- sw changes 0x00→0x3C at cycle t → reading 0x21 gives 0x00 through t+1 and 0x3C from t+2.
- RELOAD=0x0003, CTRL=0x03 → interrupt rises 4 cycles after the EN write and every 4 cycles after. OUT 0x33 clears it. A clear written on the fire cycle leaves interrupt=1.
- CTRL=0x01 (one-shot), RELOAD=0x0005 → a single fire. EN then reads 0 and the counter holds 0.
- tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 → TX_STATUS=0x44 (full, count 4); 0x55 dropped, so overflow=1 and TX_STATUS=0xC4. Raise tx_ready → bytes out 0x11,0x22,0x33,0x44 in order, then tx_valid=0 and TX_STATUS=0xA0. Write 0x80 to 0x41 → TX_STATUS=0x20.
- FIFO full with tx_ready=1 and a push of 0x66 in the same cycle → count stays 4, overflow stays 0, 0x66 is delivered last. Assert rst mid-stream → tx_valid=0 and interrupt=0 the next cycle.
